// File: rtl/ysyx_220053_trap_pkg.sv
// rtl/ysyx_220053_trap_pkg.sv - shared states, CSR addresses and cause codes for the trap unit
package ysyx_220053_trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_READ_VEC,
        ST_READ_EPC,
        ST_REDIRECT
    } trap_state_e;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [1:0] KIND_ECALL   = 2'b00;
    localparam logic [1:0] KIND_EBREAK  = 2'b01;
    localparam logic [1:0] KIND_ILLEGAL = 2'b10;
    localparam logic [1:0] KIND_MRET    = 2'b11;

    // Low cause bits; the vectored-interrupt offset only ever looks at these.
    localparam int          CAUSE_CODE_W   = 6;
    localparam logic [5:0]  EXC_ILLEGAL    = 6'd2;
    localparam logic [5:0]  EXC_BREAKPOINT = 6'd3;
    localparam logic [5:0]  EXC_ECALL_M    = 6'd11;
    localparam logic [5:0]  IRQ_TIMER_M    = 6'd7;

    localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/ysyx_220053_trap_cause.sv
// rtl/ysyx_220053_trap_cause.sv - maps trap kind or timer interrupt onto an mcause value
module ysyx_220053_trap_cause
    import ysyx_220053_trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            irq_i,
    input  logic [1:0]      kind_i,
    output logic [XLEN-1:0] cause_o
);

    always_comb begin
        cause_o = '0;
        if (irq_i) begin
            cause_o[XLEN-1]             = 1'b1;
            cause_o[CAUSE_CODE_W-1:0]   = IRQ_TIMER_M;
        end else begin
            case (kind_i)
                KIND_ECALL:   cause_o[CAUSE_CODE_W-1:0] = EXC_ECALL_M;
                KIND_EBREAK:  cause_o[CAUSE_CODE_W-1:0] = EXC_BREAKPOINT;
                KIND_ILLEGAL: cause_o[CAUSE_CODE_W-1:0] = EXC_ILLEGAL;
                default:      cause_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_220053_trap_unit.sv
// rtl/ysyx_220053_trap_unit.sv - machine-mode trap/mret sequencer: saves mepc/mcause, reads mtvec/mepc, redirects fetch
module ysyx_220053_trap_unit
    import ysyx_220053_trap_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [1:0]        trap_kind,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              irq_pending,
    input  logic [XLEN-1:0]   irq_pc,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_id,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              flush,
    output logic              busy,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    trap_state_e       state_q;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic              csr_wen_q;
    logic [CSR_AW-1:0] csr_id_q;
    logic [XLEN-1:0]   csr_wdata_q;
    logic              flush_q;
    logic              redirect_valid_q;

    logic [XLEN-1:0]   epc_d;
    logic [XLEN-1:0]   cause_d;
    logic [XLEN-1:0]   vec_base;
    logic [XLEN-1:0]   redirect_pc_d;

    // An explicit request always wins; the interrupt stays pending until a free IDLE cycle.
    assign epc_d = trap_valid ? trap_pc : irq_pc;

    ysyx_220053_trap_cause #(
        .XLEN (XLEN)
    ) u_cause (
        .irq_i   (~trap_valid),
        .kind_i  (trap_kind),
        .cause_o (cause_d)
    );

    always_comb begin
        vec_base      = csr_rdata & ALIGN_MASK;
        redirect_pc_d = vec_base;
        if (state_q == ST_READ_VEC && cause_q[XLEN-1] &&
            csr_rdata[1:0] == MTVEC_MODE_VECTORED) begin
            redirect_pc_d = vec_base + XLEN'({cause_q[CAUSE_CODE_W-1:0], 2'b00});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            epc_q            <= '0;
            cause_q          <= '0;
            redirect_pc_q    <= '0;
            csr_wen_q        <= 1'b0;
            csr_id_q         <= '0;
            csr_wdata_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            csr_wen_q        <= 1'b0;
            csr_id_q         <= '0;
            csr_wdata_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trap_valid && trap_kind == KIND_MRET) begin
                        state_q  <= ST_READ_EPC;
                        flush_q  <= 1'b1;
                        csr_id_q <= CSR_AW'(CSR_MEPC);
                    end else if (trap_valid || irq_pending) begin
                        state_q     <= ST_SAVE_EPC;
                        flush_q     <= 1'b1;
                        epc_q       <= epc_d;
                        cause_q     <= cause_d;
                        csr_wen_q   <= 1'b1;
                        csr_id_q    <= CSR_AW'(CSR_MEPC);
                        csr_wdata_q <= epc_d;
                    end
                end
                ST_SAVE_EPC: begin
                    state_q     <= ST_SAVE_CAUSE;
                    csr_wen_q   <= 1'b1;
                    csr_id_q    <= CSR_AW'(CSR_MCAUSE);
                    csr_wdata_q <= cause_q;
                end
                ST_SAVE_CAUSE: begin
                    state_q  <= ST_READ_VEC;
                    csr_id_q <= CSR_AW'(CSR_MTVEC);
                end
                ST_READ_VEC: begin
                    state_q          <= ST_REDIRECT;
                    redirect_pc_q    <= redirect_pc_d;
                    redirect_valid_q <= 1'b1;
                end
                ST_READ_EPC: begin
                    state_q          <= ST_REDIRECT;
                    redirect_pc_q    <= csr_rdata & ALIGN_MASK;
                    redirect_valid_q <= 1'b1;
                end
                ST_REDIRECT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held so an aborted sequence never leaks a write or redirect.
    assign trap_ready     = ~rst && (state_q == ST_IDLE);
    assign busy           = ~rst && (state_q != ST_IDLE);
    assign csr_wen        = ~rst && csr_wen_q;
    assign csr_id         = rst ? '0 : csr_id_q;
    assign csr_wdata      = rst ? '0 : csr_wdata_q;
    assign flush          = ~rst && flush_q;
    assign redirect_valid = ~rst && redirect_valid_q;
    assign redirect_pc    = rst ? '0 : redirect_pc_q;

endmodule

// File: tb/tb_ysyx_220053_trap_unit.sv
// tb/tb_ysyx_220053_trap_unit.sv - self-checking bench for ysyx_220053_trap_unit
module tb_ysyx_220053_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid;
    logic        trap_ready;
    logic [1:0]  trap_kind;
    logic [63:0] trap_pc;
    logic        irq_pending;
    logic [63:0] irq_pc;
    logic        csr_wen;
    logic [11:0] csr_id;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic [63:0] mtvec_m;
    logic [63:0] mepc_m;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  kind;
        bit          irq;
        logic [63:0] pc;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic [63:0] exp_cause;
        logic [63:0] exp_target;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    always_comb begin
        if (csr_id == 12'h305)      csr_rdata = mtvec_m;
        else if (csr_id == 12'h341) csr_rdata = mepc_m;
        else                        csr_rdata = 64'h0;
    end

    ysyx_220053_trap_unit #(
        .XLEN   (64),
        .CSR_AW (12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trap_valid     (trap_valid),
        .trap_ready     (trap_ready),
        .trap_kind      (trap_kind),
        .trap_pc        (trap_pc),
        .irq_pending    (irq_pending),
        .irq_pc         (irq_pc),
        .csr_wen        (csr_wen),
        .csr_id         (csr_id),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .flush          (flush),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string nm, input int id, input int cyc,
                       input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s id=%0d cyc=%0d got=%0h want=%0h", nm, id, cyc, got, want);
        end
    endtask

    // {csr_wen, csr_id, csr_wdata, flush, redirect_valid, busy, trap_ready}
    function automatic logic [80:0] got_row();
        return {csr_wen, csr_id, csr_wdata, flush, redirect_valid, busy, trap_ready};
    endfunction

    // Cycle-by-cycle picture of a sequence, k cycles after acceptance.
    function automatic logic [80:0] exp_row(bit mret, int k, logic [63:0] pc, logic [63:0] cause);
        if (mret) begin
            case (k)
                1:       return {1'b1 ^ 1'b1, 12'h341, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
                2:       return {1'b0, 12'h000, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0};
                default: return {80'h0, 1'b1};
            endcase
        end
        case (k)
            1:       return {1'b1, 12'h341, pc,    1'b1, 1'b0, 1'b1, 1'b0};
            2:       return {1'b1, 12'h342, cause, 1'b0, 1'b0, 1'b1, 1'b0};
            3:       return {1'b0, 12'h305, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0};
            4:       return {1'b0, 12'h000, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0};
            default: return {80'h0, 1'b1};
        endcase
    endfunction

    function automatic logic [63:0] model_cause(bit irq, logic [1:0] kind);
        if (irq) return 64'h8000_0000_0000_0007;
        case (kind)
            2'd0:    return 64'd11;
            2'd1:    return 64'd3;
            default: return 64'd2;
        endcase
    endfunction

    function automatic logic [63:0] model_target(bit irq, logic [1:0] kind, logic [63:0] cause,
                                                 logic [63:0] mtvec, logic [63:0] mepc);
        logic [63:0] base;
        base = mtvec - (mtvec % 4);
        if (!irq && kind == 2'd3) return mepc - (mepc % 4);
        if (irq && (mtvec % 4) == 1) return base + 4 * (cause % 64);
        return base;
    endfunction

    task automatic wait_ready(input int id);
        int guard = 0;
        while (!trap_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_before_request", id, 0, trap_ready, 1);
    endtask

    task automatic run_seq(input int id, input logic [1:0] kind, input bit irq, input logic [63:0] pc,
                           input logic [63:0] mtvec, input logic [63:0] mepc,
                           input logic [63:0] cause, input logic [63:0] target);
        bit mret;
        int kr;
        mret = !irq && kind == 2'd3;
        kr   = mret ? 2 : 4;
        @(negedge clk);
        wait_ready(id);
        mtvec_m = mtvec;
        mepc_m  = mepc;
        if (irq) begin
            irq_pending = 1'b1;
            irq_pc      = pc;
        end else begin
            trap_valid = 1'b1;
            trap_kind  = kind;
            trap_pc    = pc;
        end
        for (int k = 1; k <= kr + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                trap_valid  = 1'b0;
                irq_pending = 1'b0;
                trap_pc     = ~pc;
                irq_pc      = ~pc;
            end
            chk("row", id, k, got_row(), exp_row(mret, k, pc, cause));
            if (k == kr) chk("redirect_pc", id, k, redirect_pc, target);
        end
    endtask

    initial begin
        int acc;
        int wr;
        int viol;
        logic [63:0] p1;
        logic [63:0] p2;

        vecs[0] = '{2'd0, 1'b0, 64'h8000_0100, 64'h8000_0000, 64'h0, 64'd11, 64'h8000_0000};
        vecs[1] = '{2'd3, 1'b0, 64'h0000_0040, 64'h8000_0000, 64'h8000_0104, 64'h0, 64'h8000_0104};
        vecs[2] = '{2'd0, 1'b1, 64'h8000_0200, 64'h8000_0001, 64'h0, 64'h8000_0000_0000_0007, 64'h8000_001C};
        vecs[3] = '{2'd1, 1'b0, 64'h0000_1234, 64'h8000_0001, 64'h0, 64'd3, 64'h8000_0000};
        vecs[4] = '{2'd2, 1'b0, 64'h0000_0ABC, 64'h0000_2003, 64'h0, 64'd2, 64'h0000_2000};
        vecs[5] = '{2'd0, 1'b1, 64'h0000_5550, 64'h0000_4002, 64'h0, 64'h8000_0000_0000_0007, 64'h0000_4000};
        vecs[6] = '{2'd0, 1'b1, 64'h0000_7770, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 64'h8000_0000_0000_0007, 64'h0000_0000_0000_000C};
        vecs[7] = '{2'd3, 1'b0, 64'h0000_0080, 64'h0, 64'h8000_0107, 64'h0, 64'h8000_0104};

        rst = 1'b1; trap_valid = 1'b0; trap_kind = 2'd0; trap_pc = 64'h0;
        irq_pending = 1'b0; irq_pc = 64'h0; mtvec_m = 64'h0; mepc_m = 64'h0;

        repeat (3) @(negedge clk);
        chk("reset_row", 0, 0, got_row(), 81'h0);
        chk("reset_rpc", 0, 0, redirect_pc, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_row", 0, 1, got_row(), {80'h0, 1'b1});

        for (int i = 0; i < 8; i++)
            run_seq(i + 1, vecs[i].kind, vecs[i].irq, vecs[i].pc, vecs[i].mtvec, vecs[i].mepc,
                    vecs[i].exp_cause, vecs[i].exp_target);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  k;
            bit          q;
            logic [63:0] pc, tv, ep, c;
            k  = 2'($urandom_range(0, 3));
            q  = ($urandom_range(0, 3) == 0);
            pc = {$urandom, $urandom};
            tv = {$urandom, $urandom};
            ep = {$urandom, $urandom};
            c  = model_cause(q, k);
            run_seq(100 + i, k, q, pc, tv, ep, c, model_target(q, k, c, tv, ep));
        end

        // Illegal and interrupt together: illegal first, interrupt right after the redirect.
        p1 = 64'h0000_0000_0000_0A00;
        p2 = 64'h0000_0000_0000_0B00;
        @(negedge clk);
        wait_ready(200);
        mtvec_m = 64'h1001;
        trap_valid = 1'b1; trap_kind = 2'd2; trap_pc = p1;
        irq_pending = 1'b1; irq_pc = p2;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) trap_valid = 1'b0;
            if (k == 6) irq_pending = 1'b0;
            if (k <= 5) chk("both_row", 200, k, got_row(), exp_row(1'b0, k, p1, 64'd2));
            else        chk("both_row", 200, k, got_row(), exp_row(1'b0, k - 5, p2, 64'h8000_0000_0000_0007));
            if (k == 4) chk("both_rpc", 200, k, redirect_pc, 64'h1000);
            if (k == 9) chk("both_rpc", 200, k, redirect_pc, 64'h101C);
        end

        // Reset in the mcause-write cycle of an ecall.
        @(negedge clk);
        wait_ready(300);
        mtvec_m = 64'h8000_0000;
        trap_valid = 1'b1; trap_kind = 2'd0; trap_pc = 64'h8000_0100;
        @(negedge clk);
        trap_valid = 1'b0;
        chk("abort_t1", 300, 1, got_row(), exp_row(1'b0, 1, 64'h8000_0100, 64'd11));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_in_reset", 300, 2, got_row(), 81'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        viol = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("abort_ready", 300, 3, trap_ready, 1);
            if (csr_wen || redirect_valid || busy) viol++;
        end
        chk("abort_quiet", 300, 9, viol, 0);

        // trap_valid held high: one acceptance per five cycles.
        @(negedge clk);
        wait_ready(400);
        trap_valid = 1'b1; trap_kind = 2'd0; trap_pc = 64'h8000_0300;
        acc = 0;
        wr  = 0;
        for (int c = 0; c < 15; c++) begin
            if (trap_valid && trap_ready) acc++;
            if (csr_wen && csr_id == 12'h342) wr++;
            @(negedge clk);
        end
        trap_valid = 1'b0;
        chk("held_accepts", 400, 15, acc, 3);
        chk("held_cause_writes", 400, 15, wr, 3);
        wait_ready(401);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
